// File: rtl/down_counter_pkg.sv
// ---------------------------------------------------------------------------
// down_counter_pkg
//   Shared types and constants for the down-counter sequencer slice.
//
//   Contents:
//     DEFAULT_WIDTH  default counter width in bits
//     ctrl_state_t   sequencer FSM state (idle / counting / done)
//
//   The state labels carry an ST_ prefix so the DONE state never collides
//   with the sequencer's DONE output port when the package is wildcard
//   imported.
// ---------------------------------------------------------------------------
package down_counter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_t;

endpackage : down_counter_pkg

// File: rtl/down_counter_core.sv
// ---------------------------------------------------------------------------
// down_counter_core
//   Loadable WIDTH-bit down counter datapath. It has no notion of modes or
//   terminal-count policy; the sequencer above decides when to load and when
//   to decrement.
//
//   Ports:
//     clk   in   1      rising-edge clock
//     rst   in   1      synchronous active-high reset, clears the count
//     load  in   1      load d into the count (wins over en)
//     d     in   WIDTH  load value
//     en    in   1      decrement by one when the count is non-zero
//     q     out  WIDTH  current count (registered)
//     zero  out  1      count is zero (decoded from the register)
// ---------------------------------------------------------------------------
module down_counter_core
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en && !zero) begin
      // Saturates at zero: the count never wraps to all-ones.
      q <= q - WIDTH'(1);
    end
  end

  assign zero = (q == '0);

endmodule : down_counter_core

// File: rtl/down_counter_sequencer.sv
// ---------------------------------------------------------------------------
// down_counter_sequencer
//   Control layer above down_counter_core. Loads a start value on START,
//   decrements once per clock, pauses while HOLD is high, pulses TC for one
//   cycle at terminal count and then either stops in DONE (one-shot) or
//   reloads the start value and keeps counting (periodic).
//
//   Build option:
//     DOWN_COUNTER_AUTORELOAD_EN  when defined, RELOAD latched at START picks
//                                 periodic mode. When undefined, RELOAD is
//                                 ignored, the reload/mode registers do not
//                                 exist and every terminal count ends in DONE.
//
//   Ports:
//     CLK       in   1      rising-edge clock
//     RST       in   1      synchronous active-high reset, overrides all
//     START     in   1      load LOAD_VAL and enter counting
//     LOAD_VAL  in   WIDTH  start value, sampled only with START
//     RELOAD    in   1      periodic-mode select, sampled only with START
//     HOLD      in   1      freeze counting while high
//     Q         out  WIDTH  current count
//     BUSY      out  1      high while counting
//     TC        out  1      one-cycle terminal-count pulse
//     DONE      out  1      high once a one-shot run has finished
//
//   All outputs are registered; nothing combinational reaches a port.
// ---------------------------------------------------------------------------
module down_counter_sequencer
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             RELOAD,
  input  logic             HOLD,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             TC,
  output logic             DONE
);

  ctrl_state_t      state;
  logic             zero;
  logic             core_load;
  logic             core_en;
  logic [WIDTH-1:0] core_d;
  logic             advance;   // counting and not paused this cycle
  logic             periodic;  // current run reloads at terminal count

  assign advance = (state == ST_COUNT) && !HOLD;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic             mode_q;

  // Reload and mode only change on START or reset; HOLD and terminal count
  // leave them alone so every period restarts from the same value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      reload_q <= '0;
      mode_q   <= 1'b0;
    end else if (START) begin
      reload_q <= LOAD_VAL;
      mode_q   <= RELOAD;
    end
  end

  assign periodic  = mode_q;
  // Terminal count in periodic mode reloads through the same load port as
  // START, so Q shows the start value in the same cycle TC is high.
  assign core_load = START || (advance && zero && mode_q);
  assign core_d    = START ? LOAD_VAL : reload_q;
`else
  logic unused_reload;

  assign unused_reload = RELOAD;
  assign periodic      = 1'b0;
  assign core_load     = START;
  assign core_d        = LOAD_VAL;
`endif

  // Decrement only while actually counting; the zero case is the terminal
  // cycle and is handled by the FSM (and the reload path above).
  assign core_en = advance && !zero;

  down_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk  (CLK),
    .rst  (RST),
    .load (core_load),
    .d    (core_d),
    .en   (core_en),
    .q    (Q),
    .zero (zero)
  );

  // FSM with BUSY/TC/DONE registered alongside the state so that BUSY drops
  // on the same edge that raises TC and DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      BUSY  <= 1'b0;
      TC    <= 1'b0;
      DONE  <= 1'b0;
    end else if (START) begin
      // A restart abandons the current run without a TC pulse.
      state <= ST_COUNT;
      BUSY  <= 1'b1;
      TC    <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        ST_COUNT: begin
          if (HOLD || !zero) begin
            TC <= 1'b0;
          end else begin
            TC <= 1'b1;
            if (!periodic) begin
              state <= ST_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          TC <= 1'b0;
        end
        default: begin
          TC <= 1'b0;
        end
      endcase
    end
  end

endmodule : down_counter_sequencer

// File: tb/tb_down_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_down_counter_sequencer
//   Directed bench for down_counter_sequencer (WIDTH=3). A rule-level model
//   of the counter is stepped on every rising edge and compared against the
//   DUT just after it; the stimulus sequence also checks hand-computed
//   literal values at key points of each scenario.
// ---------------------------------------------------------------------------
module tb_down_counter_sequencer;

  localparam int W = 3;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         CLK      = 1'b0;
  logic         RST      = 1'b1;
  logic         START    = 1'b1;
  logic [W-1:0] LOAD_VAL = '0;
  logic         RELOAD   = 1'b0;
  logic         HOLD     = 1'b0;
  logic [W-1:0] Q;
  logic         BUSY;
  logic         TC;
  logic         DONE;

  int checks = 0;
  int errors = 0;

  down_counter_sequencer #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .LOAD_VAL (LOAD_VAL),
    .RELOAD   (RELOAD),
    .HOLD     (HOLD),
    .Q        (Q),
    .BUSY     (BUSY),
    .TC       (TC),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- rule-level model ---------------------------------------------------
  // phase: 0 idle, 1 counting, 2 finished. Terminal count is "a non-held
  // edge that finds the count already at zero".
  int m_q     = 0;
  int m_phase = 0;
  int m_start = 0;
  bit m_tc    = 0;
  bit m_per   = 0;
  bit m_on    = 0;

  always @(posedge CLK) begin
    if (RST) begin
      m_q = 0; m_phase = 0; m_tc = 0; m_per = 0; m_start = 0; m_on = 1;
    end else if (START) begin
      m_q = int'(LOAD_VAL); m_start = int'(LOAD_VAL);
      m_per = AR && RELOAD; m_phase = 1; m_tc = 0;
    end else if (m_phase == 1 && !HOLD) begin
      m_tc = (m_q == 0);
      if (m_q > 0)      m_q = m_q - 1;
      else if (m_per)   m_q = m_start;
      else              m_phase = 2;
    end else begin
      m_tc = 0;
    end
    #1;
    if (m_on) begin
      chk("model_q",    Q,    m_q);
      chk("model_busy", BUSY, m_phase == 1);
      chk("model_tc",   TC,   m_tc);
      chk("model_done", DONE, m_phase == 2);
    end
  end

  // ---- stimulus helpers ---------------------------------------------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic go(input int v, input bit r);
    LOAD_VAL = W'(v);
    RELOAD   = r;
    START    = 1'b1;
    tick();
    START    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tcs, first, n;
    bit found, saw;

    // Reset held for two edges with START also high.
    repeat (2) tick();
    RST = 1'b0; START = 1'b0;
    chk("rst_q", Q, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_tc", TC, 0);
    chk("rst_done", DONE, 0);
    LOAD_VAL = 3'd6; HOLD = 1'b1;
    tick();
    chk("idle_q", Q, 0);
    chk("idle_busy", BUSY, 0);
    HOLD = 1'b0;

    // One-shot from 5.
    go(5, 0);
    chk("os_load", Q, 5);
    chk("os_busy", BUSY, 1);
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk("os_q", Q, i);
      chk("os_no_tc", TC, 0);
    end
    tick();
    chk("os_tc", TC, 1);
    chk("os_done", DONE, 1);
    chk("os_busy_drop", BUSY, 0);
    chk("os_q_end", Q, 0);
    chk("pin_model_tc", m_tc, 1);
    tick();
    chk("os_tc_drop", TC, 0);
    chk("os_done_held", DONE, 1);
    HOLD = 1'b1; LOAD_VAL = 3'd7;
    repeat (2) tick();
    chk("os_done_persist", DONE, 1);
    chk("os_q_zero", Q, 0);
    HOLD = 1'b0;

    // Periodic request from 3: 3 pulses with auto-reload, else one then DONE.
    go(3, 1);
    tcs = 0; first = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (TC === 1'b1) begin
        tcs++;
        if (first < 0) first = i;
        chk("per_q_at_tc", Q, AR ? 3 : 0);
      end
    end
    chk("per_tc_count", tcs, AR ? 3 : 1);
    chk("per_first_tc", first, 4);
    chk("per_done", DONE, AR ? 0 : 1);

    // HOLD for 3 edges while Q=2 delays TC from edge 5 to edge 8.
    go(4, 0);
    tick(); tick();
    chk("hold_q_pre", Q, 2);
    HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q_frozen", Q, 2);
      chk("hold_busy", BUSY, 1);
    end
    HOLD = 1'b0;
    n = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      n++;
      if (TC === 1'b1) found = 1;
    end
    chk("hold_tc_seen", found, 1);
    chk("hold_tc_latency", 2 + 3 + n, 8);

    // Restart with 0 mid-run: no TC from the abandoned run.
    go(6, 0);
    saw = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (TC === 1'b1) saw = 1;
    end
    chk("rs_q3", Q, 3);
    go(0, 0);
    if (TC === 1'b1) saw = 1;
    chk("rs_no_tc", saw, 0);
    chk("rs_q0", Q, 0);
    chk("rs_busy", BUSY, 1);
    tick();
    chk("rs_tc", TC, 1);
    chk("rs_done", DONE, 1);

    // Reset mid-count, then a clean run from 7.
    go(4, 0);
    tick(); tick();
    chk("rm_q2", Q, 2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rm_q", Q, 0);
    chk("rm_busy", BUSY, 0);
    chk("rm_tc", TC, 0);
    chk("rm_done", DONE, 0);
    tick();
    chk("rm_idle_tc", TC, 0);
    chk("pin_model_idle", m_phase, 0);
    go(7, 0);
    chk("rm_load7", Q, 7);
    for (int i = 6; i >= 0; i--) begin
      tick();
      chk("rm_q_seq", Q, i);
    end
    tick();
    chk("rm_tc_end", TC, 1);
    chk("rm_done_end", DONE, 1);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_down_counter_sequencer
